cv32e40p_wb_arbiter: RTL and testbench



---
 rtl/cv32e40p_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_cv32e40p_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_wb_arbiter.sv
// Write-back arbiter for the two register file write ports.
// Port A: registered EX results. Port B: LSU load returns (priority) or
// buffered APU results. Also keeps a per-register outstanding-load
// scoreboard used for read-after-load hazard detection.
module cv32e40p_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned APU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,

  input  logic                  lsu_rvalid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,

  input  logic                  apu_valid_i,
  input  logic [ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [DATA_WIDTH-1:0] apu_result_i,
  output logic                  apu_ready_o,

  input  logic                  load_issue_i,
  input  logic [ADDR_WIDTH-1:0] load_issue_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  load_hazard_o,
  output logic                  lsu_pending_o,

  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  wb_collision_o
);

  localparam int unsigned NREG  = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = (APU_FIFO_DEPTH > 1) ? $clog2(APU_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(APU_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(APU_FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(APU_FIFO_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] fifo_addr [APU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [APU_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [NREG-1:0]       sb_q, sb_set, sb_clr;

  logic                  push, pop;
  logic                  nxt_we_a;
  logic                  nxt_we_b;
  logic [ADDR_WIDTH-1:0] nxt_waddr_b;
  logic [DATA_WIDTH-1:0] nxt_wdata_b;
  logic                  clash;

  // Ready depends only on registered occupancy; held low during reset.
  assign apu_ready_o = rst_n && (count < DEPTH_C);
  assign push        = apu_valid_i && apu_ready_o;
  assign pop         = (count != '0) && !lsu_rvalid_i;

  // Next-cycle port values, x0 suppression and A/B address clash detection.
  always_comb begin
    nxt_we_a    = ex_we_i && (ex_waddr_i != '0);
    nxt_we_b    = 1'b0;
    nxt_waddr_b = '0;
    nxt_wdata_b = '0;
    if (lsu_rvalid_i) begin
      nxt_we_b    = (lsu_waddr_i != '0);
      nxt_waddr_b = lsu_waddr_i;
      nxt_wdata_b = lsu_rdata_i;
    end else if (count != '0) begin
      nxt_we_b    = (fifo_addr[rd_ptr] != '0);
      nxt_waddr_b = fifo_addr[rd_ptr];
      nxt_wdata_b = fifo_data[rd_ptr];
    end
    clash = nxt_we_a && nxt_we_b && (ex_waddr_i == nxt_waddr_b);
  end

  // Scoreboard set/clear vectors; bit 0 is never set.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (load_issue_i && (load_issue_addr_i != '0)) sb_set[load_issue_addr_i] = 1'b1;
    if (lsu_rvalid_i)                              sb_clr[lsu_waddr_i]       = 1'b1;
  end

  assign load_hazard_o = sb_q[raddr_a_i] | sb_q[raddr_b_i] | sb_q[raddr_c_i];
  assign lsu_pending_o = |sb_q;

  // APU FIFO storage; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= apu_waddr_i;
      fifo_data[wr_ptr] <= apu_result_i;
    end
  end

  // Control state, output registers and scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      sb_q           <= '0;
      we_a_o         <= 1'b0;
      waddr_a_o      <= '0;
      wdata_a_o      <= '0;
      we_b_o         <= 1'b0;
      waddr_b_o      <= '0;
      wdata_b_o      <= '0;
      wb_collision_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Set is applied after clear so a same-cycle issue keeps the bit.
      sb_q <= (sb_q & ~sb_clr) | sb_set;

      we_a_o         <= nxt_we_a;
      waddr_a_o      <= ex_waddr_i;
      wdata_a_o      <= ex_wdata_i;
      we_b_o         <= nxt_we_b && !clash;
      waddr_b_o      <= nxt_waddr_b;
      wdata_b_o      <= nxt_wdata_b;
      wb_collision_o <= clash;
    end
  end

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Directed self-checking bench for cv32e40p_wb_arbiter.
module tb_cv32e40p_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we_i;
  logic [5:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_rvalid_i;
  logic [5:0]  lsu_waddr_i;
  logic [31:0] lsu_rdata_i;
  logic        apu_valid_i;
  logic [5:0]  apu_waddr_i;
  logic [31:0] apu_result_i;
  logic        apu_ready_o;
  logic        load_issue_i;
  logic [5:0]  load_issue_addr_i;
  logic [5:0]  raddr_a_i, raddr_b_i, raddr_c_i;
  logic        load_hazard_o, lsu_pending_o;
  logic        we_a_o, we_b_o, wb_collision_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;

  int n_cmp = 0;
  int n_err = 0;

  cv32e40p_wb_arbiter #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .APU_FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex_we_i(ex_we_i),
    .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i),
    .lsu_rvalid_i(lsu_rvalid_i),
    .lsu_waddr_i(lsu_waddr_i),
    .lsu_rdata_i(lsu_rdata_i),
    .apu_valid_i(apu_valid_i),
    .apu_waddr_i(apu_waddr_i),
    .apu_result_i(apu_result_i),
    .apu_ready_o(apu_ready_o),
    .load_issue_i(load_issue_i),
    .load_issue_addr_i(load_issue_addr_i),
    .raddr_a_i(raddr_a_i),
    .raddr_b_i(raddr_b_i),
    .raddr_c_i(raddr_c_i),
    .load_hazard_o(load_hazard_o),
    .lsu_pending_o(lsu_pending_o),
    .we_a_o(we_a_o),
    .waddr_a_o(waddr_a_o),
    .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o),
    .waddr_b_o(waddr_b_o),
    .wdata_b_o(wdata_b_o),
    .wb_collision_o(wb_collision_o)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    lsu_rvalid_i = 1'b0; lsu_waddr_i = '0; lsu_rdata_i = '0;
    apu_valid_i = 1'b0; apu_waddr_i = '0; apu_result_i = '0;
    load_issue_i = 1'b0; load_issue_addr_i = '0;
    raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready",   apu_ready_o, 0);
    chk("rst_we_a",    we_a_o, 0);
    chk("rst_we_b",    we_b_o, 0);
    chk("rst_pending", lsu_pending_o, 0);
    chk("rst_coll",    wb_collision_o, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", apu_ready_o, 1);

    // Port A pass-through
    ex_we_i = 1'b1; ex_waddr_i = 6'd5; ex_wdata_i = 32'hDEADBEEF;
    tick();
    chk("pa_we",    we_a_o, 1);
    chk("pa_addr",  waddr_a_o, 5);
    chk("pa_data",  wdata_a_o, 32'hDEADBEEF);
    chk("pa_we_b",  we_b_o, 0);
    ex_we_i = 1'b0;
    tick();
    chk("pa_we_off", we_a_o, 0);

    // APU fill while LSU holds port B
    lsu_rvalid_i = 1'b1; lsu_waddr_i = 6'd20; lsu_rdata_i = 32'h1;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd8; apu_result_i = 32'h80;
    tick();
    chk("fill_b0_addr", waddr_b_o, 20);
    chk("fill_b0_data", wdata_b_o, 32'h1);
    chk("fill_ready1",  apu_ready_o, 1);
    lsu_waddr_i = 6'd21; lsu_rdata_i = 32'h2;
    apu_waddr_i = 6'd9; apu_result_i = 32'h90;
    tick();
    chk("fill_ready_full", apu_ready_o, 0);
    lsu_waddr_i = 6'd22; lsu_rdata_i = 32'h3;
    apu_waddr_i = 6'd10; apu_result_i = 32'hA0;
    tick();
    chk("stall_ready", apu_ready_o, 0);
    chk("stall_b_we",  we_b_o, 1);
    chk("stall_b_addr", waddr_b_o, 22);
    lsu_rvalid_i = 1'b0;
    tick();
    chk("drain8_we",   we_b_o, 1);
    chk("drain8_addr", waddr_b_o, 8);
    chk("drain8_data", wdata_b_o, 32'h80);
    chk("drain_ready", apu_ready_o, 1);
    tick();
    apu_valid_i = 1'b0;
    chk("drain9_addr", waddr_b_o, 9);
    chk("drain9_data", wdata_b_o, 32'h90);
    tick();
    chk("drain10_addr", waddr_b_o, 10);
    chk("drain10_data", wdata_b_o, 32'hA0);
    tick();
    chk("drain_empty_we", we_b_o, 0);

    // Collision
    ex_we_i = 1'b1; ex_waddr_i = 6'd12; ex_wdata_i = 32'hA;
    lsu_rvalid_i = 1'b1; lsu_waddr_i = 6'd12; lsu_rdata_i = 32'hB;
    tick();
    ex_we_i = 1'b0; lsu_rvalid_i = 1'b0;
    chk("coll_we_a",  we_a_o, 1);
    chk("coll_data_a", wdata_a_o, 32'hA);
    chk("coll_we_b",  we_b_o, 0);
    chk("coll_pulse", wb_collision_o, 1);
    tick();
    chk("coll_end",   wb_collision_o, 0);
    chk("coll_no_retry", we_b_o, 0);

    // Scoreboard
    raddr_b_i = 6'd7;
    load_issue_i = 1'b1; load_issue_addr_i = 6'd7;
    chk("sb_before", load_hazard_o, 0);
    tick();
    load_issue_i = 1'b0;
    chk("sb_set_haz",  load_hazard_o, 1);
    chk("sb_pending",  lsu_pending_o, 1);
    lsu_rvalid_i = 1'b1; lsu_waddr_i = 6'd7; lsu_rdata_i = 32'h77;
    tick();
    lsu_rvalid_i = 1'b0;
    chk("sb_clr_haz",  load_hazard_o, 0);
    chk("sb_ret_addr", waddr_b_o, 7);
    chk("sb_ret_data", wdata_b_o, 32'h77);
    load_issue_i = 1'b1;
    tick();
    chk("sb_reset_haz", load_hazard_o, 1);
    lsu_rvalid_i = 1'b1;
    tick();
    load_issue_i = 1'b0;
    chk("sb_set_wins", load_hazard_o, 1);
    tick();
    lsu_rvalid_i = 1'b0;
    chk("sb_final_clr", load_hazard_o, 0);
    chk("sb_final_pend", lsu_pending_o, 0);
    raddr_b_i = 6'd0;

    // x0 handling
    apu_valid_i = 1'b1; apu_waddr_i = 6'd0; apu_result_i = 32'h55;
    tick();
    apu_valid_i = 1'b0;
    chk("x0_ready", apu_ready_o, 1);
    tick();
    chk("x0_we_b", we_b_o, 0);
    apu_valid_i = 1'b1; apu_waddr_i = 6'd3; apu_result_i = 32'h33;
    tick();
    apu_valid_i = 1'b0;
    chk("x0_lat_we", we_b_o, 0);
    tick();
    chk("x0_next_we",   we_b_o, 1);
    chk("x0_next_addr", waddr_b_o, 3);
    chk("x0_next_data", wdata_b_o, 32'h33);
    load_issue_i = 1'b1; load_issue_addr_i = 6'd0;
    tick();
    load_issue_i = 1'b0;
    chk("x0_pending", lsu_pending_o, 0);
    chk("x0_hazard",  load_hazard_o, 0);

    // Mid-operation reset
    lsu_rvalid_i = 1'b1; lsu_waddr_i = 6'd25; lsu_rdata_i = 32'h9;
    apu_valid_i = 1'b1; apu_waddr_i = 6'd14; apu_result_i = 32'hE;
    load_issue_i = 1'b1; load_issue_addr_i = 6'd3;
    tick();
    load_issue_i = 1'b0;
    apu_waddr_i = 6'd15; apu_result_i = 32'hF;
    tick();
    chk("mr_full",    apu_ready_o, 0);
    chk("mr_pending", lsu_pending_o, 1);
    lsu_rvalid_i = 1'b0; apu_valid_i = 1'b0;
    ex_we_i = 1'b1; ex_waddr_i = 6'd6; ex_wdata_i = 32'h1;
    rst_n = 1'b0;
    #1;
    chk("mr_ready_in_rst", apu_ready_o, 0);
    tick();
    chk("mr_we_a",    we_a_o, 0);
    chk("mr_waddr_a", waddr_a_o, 0);
    chk("mr_wdata_a", wdata_a_o, 0);
    chk("mr_we_b",    we_b_o, 0);
    chk("mr_waddr_b", waddr_b_o, 0);
    chk("mr_coll",    wb_collision_o, 0);
    chk("mr_pend",    lsu_pending_o, 0);
    rst_n = 1'b1; ex_we_i = 1'b0;
    tick();
    chk("mr_rel_ready", apu_ready_o, 1);
    chk("mr_rel_we_b",  we_b_o, 0);
    chk("mr_rel_pend",  lsu_pending_o, 0);
    tick();
    chk("mr_rel_we_b2", we_b_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
